// File: rtl/store_buffer_pkg.sv
// Shared widths, default depth, drain-FSM encoding and store lane masks for the store buffer.
package store_buffer_pkg;

  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 32;
  localparam int SB_DEPTH_DEF = 4;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/store_buffer_align.sv
// Lane aligner: moves LSB-justified store data and mask into the byte lanes selected by addr[1:0].
// With STORE_BUFFER_MISALIGN_EN defined it also flags halves/words that cross their natural boundary.
module store_buffer_align
  import store_buffer_pkg::*;
(
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic [3:0]        mask_i,
  output logic [AWIDTH-1:0] addr_o,
  output logic [DWIDTH-1:0] data_o,
  output logic [3:0]        be_o
`ifdef STORE_BUFFER_MISALIGN_EN
  ,
  output logic              misalign_o
`endif
);

  logic [1:0] sh;

  assign sh     = addr_i[1:0];
  assign addr_o = {addr_i[AWIDTH-1:2], 2'b00};
  // Lanes pushed past lane 3 simply fall off the top of the word.
  assign be_o   = mask_i << sh;
  assign data_o = data_i << {sh, 3'b000};

`ifdef STORE_BUFFER_MISALIGN_EN
  assign misalign_o = ((mask_i == MASK_HALF) && addr_i[0]) ||
                      ((mask_i == MASK_WORD) && (sh != 2'b00));
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: aligns stores, queues them in order, drains over req/ack, flags load hazards.
// Optional STORE_BUFFER_MISALIGN_EN rejects misaligned half/word stores and exposes sb_o_misalign.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int PTR_W    = $clog2(SB_DEPTH)
) (
  input  logic              sb_i_clk,
  input  logic              sb_i_rst,
  input  logic              sb_i_wr_en,
  input  logic [AWIDTH-1:0] sb_i_addr,
  input  logic [DWIDTH-1:0] sb_i_store_data,
  input  logic [3:0]        sb_i_store_mask,
  output logic              sb_o_full,
  output logic              sb_o_empty,
  input  logic              sb_i_ld_en,
  input  logic [AWIDTH-1:0] sb_i_ld_addr,
  output logic              sb_o_ld_hazard,
  output logic              sb_o_mem_req,
  output logic [AWIDTH-1:0] sb_o_mem_addr,
  output logic [DWIDTH-1:0] sb_o_mem_data,
  output logic [3:0]        sb_o_mem_be,
  input  logic              sb_i_mem_ack
`ifdef STORE_BUFFER_MISALIGN_EN
  ,
  output logic              sb_o_misalign
`endif
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(SB_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_ZERO = '0;

  logic [AWIDTH-1:0] al_addr;
  logic [DWIDTH-1:0] al_data;
  logic [3:0]        al_be;
  logic              al_misalign;

  logic [AWIDTH-1:0] ent_addr_q [SB_DEPTH];
  logic [DWIDTH-1:0] ent_data_q [SB_DEPTH];
  logic [3:0]        ent_be_q   [SB_DEPTH];

  sb_state_e         state_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic              full_q;
  logic              mem_req_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_data_q;
  logic [3:0]        mem_be_q;

  logic              push, pop;
  logic              hit;
  logic [PTR_W-1:0]  off;
  logic              unused_ld_lsb;

  store_buffer_align u_align (
    .addr_i     (sb_i_addr),
    .data_i     (sb_i_store_data),
    .mask_i     (sb_i_store_mask),
    .addr_o     (al_addr),
    .data_o     (al_data),
    .be_o       (al_be)
`ifdef STORE_BUFFER_MISALIGN_EN
    ,
    .misalign_o (al_misalign)
`endif
  );

`ifdef STORE_BUFFER_MISALIGN_EN
  assign sb_o_misalign = sb_i_wr_en && al_misalign;
`else
  assign al_misalign = 1'b0;
`endif

  // full_q mirrors count == SB_DEPTH, so a store offered while full is dropped even if a pop lands.
  assign push      = sb_i_wr_en && !full_q && (sb_i_store_mask != 4'b0000) && !al_misalign;
  assign pop       = (state_q == SB_REQ) && sb_i_mem_ack;
  assign rd_ptr_nx = rd_ptr_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge sb_i_clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= al_addr;
      ent_data_q[wr_ptr_q] <= al_data;
      ent_be_q[wr_ptr_q]   <= al_be;
    end
  end

  always_ff @(posedge sb_i_clk or negedge sb_i_rst) begin
    if (!sb_i_rst) begin
      state_q    <= SB_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_be_q   <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_nx;

      case (state_q)
        SB_IDLE: begin
          if (count_q != CNT_ZERO) begin
            state_q    <= SB_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= ent_addr_q[rd_ptr_q];
            mem_data_q <= ent_data_q[rd_ptr_q];
            mem_be_q   <= ent_be_q[rd_ptr_q];
          end
        end
        SB_REQ: begin
          if (sb_i_mem_ack) begin
            // More than one entry queued: the next head is already stored, present it back-to-back.
            if (count_q != CNT_ONE) begin
              mem_addr_q <= ent_addr_q[rd_ptr_nx];
              mem_data_q <= ent_data_q[rd_ptr_nx];
              mem_be_q   <= ent_be_q[rd_ptr_nx];
            end else begin
              state_q    <= SB_IDLE;
              mem_req_q  <= 1'b0;
              mem_addr_q <= '0;
              mem_data_q <= '0;
              mem_be_q   <= '0;
            end
          end
        end
        default: state_q <= SB_IDLE;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) &&
          (ent_addr_q[PTR_W'(i)][AWIDTH-1:2] == sb_i_ld_addr[AWIDTH-1:2]))
        hit = 1'b1;
    end
  end

  assign unused_ld_lsb  = ^sb_i_ld_addr[1:0];

  assign sb_o_ld_hazard = sb_i_ld_en && hit;
  assign sb_o_full      = full_q;
  assign sb_o_empty     = (count_q == CNT_ZERO) && (state_q == SB_IDLE);
  assign sb_o_mem_req   = mem_req_q;
  assign sb_o_mem_addr  = mem_addr_q;
  assign sb_o_mem_data  = mem_data_q;
  assign sb_o_mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard of expected memory writes, immediate-assert checks.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic [3:0]  smask = '0;
  logic        full, empty;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
`ifdef STORE_BUFFER_MISALIGN_EN
  logic        misalign;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .sb_i_clk        (clk),
    .sb_i_rst        (rst),
    .sb_i_wr_en      (wr_en),
    .sb_i_addr       (addr),
    .sb_i_store_data (sdata),
    .sb_i_store_mask (smask),
    .sb_o_full       (full),
    .sb_o_empty      (empty),
    .sb_i_ld_en      (ld_en),
    .sb_i_ld_addr    (ld_addr),
    .sb_o_ld_hazard  (ld_hazard),
    .sb_o_mem_req    (mem_req),
    .sb_o_mem_addr   (mem_addr),
    .sb_o_mem_data   (mem_data),
    .sb_o_mem_be     (mem_be),
    .sb_i_mem_ack    (mem_ack)
`ifdef STORE_BUFFER_MISALIGN_EN
    ,
    .sb_o_misalign   (misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs are driven at posedge+1; handshakes are scored just before the next edge.
  task automatic tick();
    exp_t e;
    #1;
    if (mem_req && mem_ack) begin
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_addr", mem_addr, e.addr);
        check("pop_data", mem_data, e.data);
        check("pop_be", {28'd0, mem_be}, {28'd0, e.be});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input bit accept, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] eb);
    exp_t e;
    wr_en = 1'b1; addr = a; sdata = d; smask = m;
    if (accept) begin
      e.addr = ea; e.data = ed; e.be = eb;
      exp_q.push_back(e);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    mem_ack = 1'b1;
    for (int i = 0; i < 20 && !empty; i++) tick();
    check(tag, {31'd0, empty}, 32'd1);
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_hazard", {31'd0, ld_hazard}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    rst = 1'b1;
    tick();

    // Reset while a request is outstanding
    store(32'h10, 32'h1111_1111, 4'b1111, 1, 32'h10, 32'h1111_1111, 4'b1111);
    store(32'h14, 32'h2222_2222, 4'b1111, 1, 32'h14, 32'h2222_2222, 4'b1111);
    check("mid_req_up", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_full", {31'd0, full}, 32'd0);
    exp_q.delete();
    mem_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("late_ack_empty", {31'd0, empty}, 32'd1);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // Alignment
    store(32'h103, 32'h0000_00AB, 4'b0001, 1, 32'h100, 32'hAB00_0000, 4'b1000);
    store(32'h102, 32'h0000_BEEF, 4'b0011, 1, 32'h100, 32'hBEEF_0000, 4'b1100);
    check("align_req", {31'd0, mem_req}, 32'd1);
    check("align_addr", mem_addr, 32'h100);
    check("align_be", {28'd0, mem_be}, 32'h8);
    drain("align_drained");

    // Fill, drop while full, then back-to-back drain
    store(32'h300, 32'hA0A0_0000, 4'b1111, 1, 32'h300, 32'hA0A0_0000, 4'b1111);
    store(32'h304, 32'hA0A0_0001, 4'b1111, 1, 32'h304, 32'hA0A0_0001, 4'b1111);
    store(32'h308, 32'hA0A0_0002, 4'b1111, 1, 32'h308, 32'hA0A0_0002, 4'b1111);
    store(32'h30C, 32'hA0A0_0003, 4'b1111, 1, 32'h30C, 32'hA0A0_0003, 4'b1111);
    check("full_set", {31'd0, full}, 32'd1);
    store(32'h310, 32'hDEAD_0004, 4'b1111, 0, '0, '0, '0);
    check("full_hold", {31'd0, full}, 32'd1);
    mem_ack = 1'b1;
    store(32'h314, 32'hDEAD_0005, 4'b1111, 0, '0, '0, '0);
    check("full_clear", {31'd0, full}, 32'd0);
    repeat (3) tick();
    check("b2b_empty", {31'd0, empty}, 32'd1);
    check("b2b_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // Push and pop in the same cycle at count 2
    store(32'h400, 32'h4444_0000, 4'b1111, 1, 32'h400, 32'h4444_0000, 4'b1111);
    store(32'h404, 32'h4444_0001, 4'b1111, 1, 32'h404, 32'h4444_0001, 4'b1111);
    mem_ack = 1'b1;
    store(32'h408, 32'h4444_0002, 4'b1111, 1, 32'h408, 32'h4444_0002, 4'b1111);
    check("pp_full", {31'd0, full}, 32'd0);
    tick();
    check("pp_one_left", {31'd0, empty}, 32'd0);
    tick();
    check("pp_empty", {31'd0, empty}, 32'd1);
    mem_ack = 1'b0;

    // Load hazard
    wr_en = 1'b1; addr = 32'h204; sdata = 32'h1234_5678; smask = 4'b1111;
    ld_en = 1'b1; ld_addr = 32'h204;
    exp_q.push_back('{addr: 32'h204, data: 32'h1234_5678, be: 4'b1111});
    #1 check("hz_same_cycle", {31'd0, ld_hazard}, 32'd0);
    tick();
    wr_en = 1'b0;
    ld_addr = 32'h206;
    #1 check("hz_hit", {31'd0, ld_hazard}, 32'd1);
    ld_addr = 32'h208;
    #1 check("hz_miss", {31'd0, ld_hazard}, 32'd0);
    ld_addr = 32'h206; ld_en = 1'b0;
    #1 check("hz_no_load", {31'd0, ld_hazard}, 32'd0);
    ld_en = 1'b1;
    tick();
    check("hz_req", {31'd0, mem_req}, 32'd1);
    check("hz_head", {31'd0, ld_hazard}, 32'd1);
    mem_ack = 1'b1;
    tick();
    check("hz_after_pop", {31'd0, ld_hazard}, 32'd0);
    check("hz_empty", {31'd0, empty}, 32'd1);
    mem_ack = 1'b0; ld_en = 1'b0;

    // Zero mask is ignored
    store(32'h500, 32'hFFFF_FFFF, 4'b0000, 0, '0, '0, '0);
    tick();
    check("mask0_empty", {31'd0, empty}, 32'd1);

`ifdef STORE_BUFFER_MISALIGN_EN
    wr_en = 1'b1; addr = 32'h102; sdata = 32'hCAFE_F00D; smask = 4'b1111;
    #1 check("mis_word", {31'd0, misalign}, 32'd1);
    tick();
    wr_en = 1'b0;
    #1 check("mis_idle", {31'd0, misalign}, 32'd0);
    tick();
    check("mis_not_pushed", {31'd0, empty}, 32'd1);
    wr_en = 1'b1; addr = 32'h101; sdata = 32'h0000_1234; smask = 4'b0011;
    #1 check("mis_half", {31'd0, misalign}, 32'd1);
    tick();
    addr = 32'h102;
    #1 check("mis_half_ok", {31'd0, misalign}, 32'd0);
    exp_q.push_back('{addr: 32'h100, data: 32'h1234_0000, be: 4'b1100});
    tick();
    wr_en = 1'b0;
    drain("mis_drained");
`else
    store(32'h102, 32'hCAFE_F00D, 4'b1111, 1, 32'h100, 32'hF00D_0000, 4'b1100);
    drain("trunc_drained");
`endif

    check("sb_all_popped", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
